cpu_mem_responder: RTL



---
 rtl/cpu_mem_responder_if.sv | 40 ++++
 rtl/cpu_mem_responder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder_if.sv
// rtl/cpu_mem_responder_if.sv - CPU instruction/data bus and RAM dump port bundle
interface cpu_mem_responder_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address_to_rom;
  logic              enable_to_rom;
  logic [DATA_W-1:0] data_from_rom;
  logic [ADDR_W-1:0] address_to_ram;
  logic [DATA_W-1:0] data_to_ram;
  logic              write_enable_to_ram;
  logic              read_enable_to_ram;
  logic [DATA_W-1:0] data_from_ram;
  logic              enable_ram_read;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              ram_ready;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;

  modport master (
    output address_to_rom, enable_to_rom, address_to_ram, data_to_ram,
           write_enable_to_ram, read_enable_to_ram, enable_ram_read,
           prog_we, prog_addr, prog_data, dump_ready,
    input  data_from_rom, data_from_ram, ram_ready, dump_valid,
           dump_addr, dump_data, dump_busy
  );

  modport slave (
    input  address_to_rom, enable_to_rom, address_to_ram, data_to_ram,
           write_enable_to_ram, read_enable_to_ram, enable_ram_read,
           prog_we, prog_addr, prog_data, dump_ready,
    output data_from_rom, data_from_ram, ram_ready, dump_valid,
           dump_addr, dump_data, dump_busy
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - instruction store, data RAM with post-reset clear and RAM dump sequencer
module cpu_mem_responder #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic                 clk_main,
  input  logic                 reset,
  cpu_mem_responder_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {
    CLEAR      = 2'd0,
    IDLE       = 2'd1,
    DUMP_FETCH = 2'd2,
    DUMP_SEND  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;

  logic [DATA_W-1:0] rom_q [DEPTH];
  logic [DATA_W-1:0] ram_q [DEPTH];

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  logic unused_read_enable;
  assign unused_read_enable = bus.read_enable_to_ram;

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    case (state_q)
      CLEAR: begin
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      IDLE: begin
        if (bus.enable_ram_read) begin
          state_d = DUMP_FETCH;
          ptr_d   = '0;
        end
      end
      DUMP_FETCH: begin
        // ram_q is sampled before this edge's CPU write lands, so a colliding write is not seen
        dump_data_d = ram_q[ptr_q];
        dump_addr_d = ptr_q;
        state_d     = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (bus.dump_ready) begin
          if (ptr_q == PTR_LAST) begin
            state_d = IDLE;
            ptr_d   = '0;
          end else begin
            state_d = DUMP_FETCH;
            ptr_d   = ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    ram_we         = 1'b0;
    ram_waddr      = bus.address_to_ram;
    ram_wdata      = bus.data_to_ram;
    bus.ram_ready  = (state_q != CLEAR);
    bus.dump_valid = (state_q == DUMP_SEND);
    bus.dump_busy  = (state_q == DUMP_FETCH) || (state_q == DUMP_SEND);
    bus.dump_addr  = dump_addr_q;
    bus.dump_data  = dump_data_q;
    // The clear sequencer owns the single write port; CPU writes are dropped meanwhile
    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = ptr_q;
      ram_wdata = '0;
    end else begin
      ram_we = bus.write_enable_to_ram;
    end
  end

  always_ff @(posedge clk_main) begin
    if (bus.prog_we) rom_q[bus.prog_addr] <= bus.prog_data;
    if (ram_we)      ram_q[ram_waddr]     <= ram_wdata;
  end

  assign bus.data_from_rom = bus.enable_to_rom ? rom_q[bus.address_to_rom] : '0;
  assign bus.data_from_ram = (state_q == CLEAR) ? '0 : ram_q[bus.address_to_ram];

endmodule
